// File: rtl/ddr4_req_arbiter.sv
// Round-robin arbiter that shares one DDR4 user command port among NUM_REQ requesters.
// An in-order requester-ID FIFO routes read responses back to the requester that issued the read.
module ddr4_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int RD_OUTST  = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         ddr4_init_calib_complete_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_rd_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         mem_en_o,
  output logic                         mem_rd_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_rdy_i,
  input  logic                         mem_rsp_valid_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [$clog2(RD_OUTST):0]    rd_outst_o,
  output logic                         rsp_err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(RD_OUTST);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         rr_q, rr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic                   rd_q, rd_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q;

  logic [IDW-1:0]         fifo_mem [RD_OUTST];
  logic [IDW-1:0]         head_id;
  logic                   fifo_full, fifo_empty;
  logic                   accept, push, pop;
  logic [NUM_REQ-1:0]     elig;
  logic                   pick_found;
  logic [IDW-1:0]         pick_id;

  assign fifo_full  = (cnt_q == CW'(RD_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign elig       = req_valid_i & ~(req_rd_i & {NUM_REQ{fifo_full}});

  // Scan from the highest offset down so the last hit is the one closest to rr_q.
  always_comb begin : pick_comb
    logic [IDW:0] idx;
    idx        = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (elig[idx[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (ddr4_init_calib_complete_i) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!ddr4_init_calib_complete_i) begin
          state_d = S_INIT;
        end else if (pick_found) begin
          id_d    = pick_id;
          rd_d    = req_rd_i[pick_id];
          addr_d  = req_addr_i[pick_id*ADDR_SIZE +: ADDR_SIZE];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Calibration loss is only acted on once the latched command has gone out.
        if (mem_rdy_i) begin
          accept  = 1'b1;
          rr_d    = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign push = accept & rd_q;
  assign pop  = mem_rsp_valid_i & ~fifo_empty;

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop & ~push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= id_q;
    end
  end

  assign head_id = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_INIT;
      rr_q     <= '0;
      id_q     <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (mem_rsp_valid_i & fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Handshake pulses are suppressed while reset is asserted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
    assign req_ready_o[gi] = accept & ~reset_i & (id_q == IDW'(gi));
    assign rsp_valid_o[gi] = pop & ~reset_i & (head_id == IDW'(gi));
  end

  assign mem_en_o   = (state_q == S_ISSUE);
  assign mem_rd_o   = rd_q;
  assign mem_addr_o = addr_q;
  assign rd_outst_o = cnt_q;
  assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_ddr4_req_arbiter.sv
// Self-checking bench for ddr4_req_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_ddr4_req_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] ADDR_A = 32'h0000_00A0;
  localparam logic [31:0] ADDR_B = 32'h0000_00B0;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        calib;
  logic [1:0]  req_valid, req_rd, req_ready, rsp_valid;
  logic [63:0] req_addr;
  logic        mem_en, mem_rd, mem_rdy, mem_rsp_valid, rsp_err;
  logic [31:0] mem_addr;
  logic [3:0]  rd_outst;

  always #5 clk_i = ~clk_i;

  ddr4_req_arbiter #(.NUM_REQ(N), .ADDR_SIZE(32), .RD_OUTST(DEPTH)) dut (
    .clk_i                      (clk_i),
    .reset_i                    (reset_i),
    .ddr4_init_calib_complete_i (calib),
    .req_valid_i                (req_valid),
    .req_rd_i                   (req_rd),
    .req_addr_i                 (req_addr),
    .req_ready_o                (req_ready),
    .mem_en_o                   (mem_en),
    .mem_rd_o                   (mem_rd),
    .mem_addr_o                 (mem_addr),
    .mem_rdy_i                  (mem_rdy),
    .mem_rsp_valid_i            (mem_rsp_valid),
    .rsp_valid_o                (rsp_valid),
    .rd_outst_o                 (rd_outst),
    .rsp_err_o                  (rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: arbitration enabled flag, one pending command, queue of read owners.
  bit          m_arb;
  bit          m_busy;
  int          m_id;
  bit          m_rd;
  logic [31:0] m_addr;
  int          m_rr;
  int          m_q[$];
  bit          m_err;

  bit          e_en, e_mrd;
  logic [31:0] e_addr;
  logic [1:0]  e_ready, e_rsp;
  int          e_outst;
  bit          e_err;

  function automatic void model_reset();
    m_arb = 0; m_busy = 0; m_id = 0; m_rd = 0; m_addr = '0; m_rr = 0; m_err = 0;
    m_q.delete();
  endfunction

  function automatic void predict();
    e_en    = m_busy;
    e_mrd   = m_rd;
    e_addr  = m_addr;
    e_ready = (!reset_i && m_busy && mem_rdy) ? 2'(1 << m_id) : 2'b00;
    e_rsp   = (!reset_i && mem_rsp_valid && m_q.size() > 0) ? 2'(1 << m_q[0]) : 2'b00;
    e_outst = m_q.size();
    e_err   = m_err;
  endfunction

  function automatic void model_update();
    int sz;
    sz = m_q.size();
    if (reset_i) begin
      model_reset();
      return;
    end
    if (mem_rsp_valid) begin
      if (sz > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (!m_arb) begin
      m_arb = calib;
    end else if (m_busy) begin
      if (mem_rdy) begin
        if (m_rd) m_q.push_back(m_id);
        m_rr   = (m_id + 1) % N;
        m_busy = 0;
      end
    end else if (!calib) begin
      m_arb = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (req_valid[k] && !(req_rd[k] && sz >= DEPTH)) begin
          m_busy = 1;
          m_id   = k;
          m_rd   = req_rd[k];
          m_addr = req_addr[k*32 +: 32];
          break;
        end
      end
    end
  endfunction

  // Called mid-cycle after inputs are applied; advances to just after the next edge.
  task automatic finish_cycle(input bit use_model);
    predict();
    if (use_model) begin
      if (!reset_i) chk("m_en", mem_en, e_en);
      if (e_en && !reset_i) begin
        chk("m_rd", mem_rd, e_mrd);
        chk("m_addr", mem_addr, e_addr);
      end
      chk("m_ready", req_ready, e_ready);
      chk("m_rspv", rsp_valid, e_rsp);
      chk("m_outst", rd_outst, e_outst);
      chk("m_err", rsp_err, e_err);
    end
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    bit          rst, cal;
    bit [1:0]    vld, rd;
    bit          rdy, rsp;
    int          cm;       // 0: skip port checks, 1: mem_en only, 2: mem_en/rd/addr
    bit          en, mrd;
    logic [31:0] addr;
    bit [1:0]    rdyo, rspo;
    int          outst;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input bit cal, input bit [1:0] vld, input bit [1:0] rd,
                              input bit rdy, input bit rsp, input int cm, input bit en, input bit mrd,
                              input logic [31:0] addr, input bit [1:0] rdyo, input bit [1:0] rspo,
                              input int outst, input bit err);
    vec_t v;
    v.rst = rst; v.cal = cal; v.vld = vld; v.rd = rd; v.rdy = rdy; v.rsp = rsp;
    v.cm = cm; v.en = en; v.mrd = mrd; v.addr = addr; v.rdyo = rdyo; v.rspo = rspo;
    v.outst = outst; v.err = err;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt0, cnt1, guard;
    bit [1:0]    p_v, p_rd, last_ready;
    logic [31:0] p_a [2];
    int          cal_hold;

    reset_i = 1; calib = 0; req_valid = 0; req_rd = 0; req_addr = {ADDR_B, ADDR_A};
    mem_rdy = 0; mem_rsp_valid = 0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();

    //        rst cal vld    rd     rdy rsp cm en mrd addr    rdyo   rspo   out err
    tbl.push_back(mk(1, 0, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 2, 1, 0, ADDR_A, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 2, 1, 0, ADDR_B, 2'b10, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 2, 1, 0, ADDR_A, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 2'b00, 1, 0, 2, 1, 0, ADDR_B, 2'b10, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b01, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b01, 1, 0, 2, 1, 1, ADDR_A, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b10, 2'b10, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 1, 0));
    tbl.push_back(mk(0, 1, 2'b10, 2'b10, 1, 0, 2, 1, 1, ADDR_B, 2'b10, 2'b00, 1, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b01, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 2, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b01, 1, 0, 2, 1, 1, ADDR_A, 2'b01, 2'b00, 2, 0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 1, 0, 0, 32'h0,  2'b00, 2'b01, 3, 0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 1, 0, 0, 32'h0,  2'b00, 2'b10, 2, 0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 1, 0, 0, 32'h0,  2'b00, 2'b01, 1, 0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 0, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 0, 0, 2, 1, 0, ADDR_A, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(1, 1, 2'b01, 2'b00, 1, 0, 0, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 2, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 1, 0, 0, 32'h0,  2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 2, 1, 0, ADDR_A, 2'b01, 2'b00, 0, 0));

    foreach (tbl[i]) begin
      reset_i = tbl[i].rst; calib = tbl[i].cal; req_valid = tbl[i].vld; req_rd = tbl[i].rd;
      mem_rdy = tbl[i].rdy; mem_rsp_valid = tbl[i].rsp;
      #3;
      if (tbl[i].cm >= 1) chk($sformatf("vec%0d_en", i), mem_en, tbl[i].en);
      if (tbl[i].cm == 2) begin
        chk($sformatf("vec%0d_mrd", i), mem_rd, tbl[i].mrd);
        chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
      end
      chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].rdyo);
      chk($sformatf("vec%0d_rspv", i), rsp_valid, tbl[i].rspo);
      chk($sformatf("vec%0d_outst", i), rd_outst, tbl[i].outst);
      chk($sformatf("vec%0d_err", i), rsp_err, tbl[i].err);
      finish_cycle(0);
    end

    // Back-pressure: the command is held with a stable address until the port accepts it.
    req_valid = 2'b10; req_rd = 2'b00; mem_rdy = 0; mem_rsp_valid = 0;
    #3; finish_cycle(1);
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("bp_en", mem_en, 1'b1);
      chk("bp_addr", mem_addr, ADDR_B);
      chk("bp_ready", req_ready, 2'b00);
      finish_cycle(1);
    end
    mem_rdy = 1;
    #3;
    chk("bp_accept", req_ready, 2'b10);
    finish_cycle(1);
    req_valid = 2'b00;

    // FIFO full: fill with requester-0 reads, then only writes may proceed.
    req_valid = 2'b01; req_rd = 2'b01; guard = 0;
    while (m_q.size() < DEPTH && guard < 40) begin
      #3; finish_cycle(1); guard++;
    end
    chk("fill_within_budget", (guard < 40), 1'b1);
    req_valid = 2'b11; req_rd = 2'b01; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 6; c++) begin
      #3;
      chk("full_outst", rd_outst, DEPTH);
      cnt0 += int'(req_ready[0]);
      cnt1 += int'(req_ready[1]);
      finish_cycle(1);
    end
    chk("full_r0_grants", cnt0, 0);
    chk("full_r1_grants", cnt1, 3);
    req_valid = 2'b01; mem_rsp_valid = 1;
    #3; chk("full_pop_rspv", rsp_valid, 2'b01); finish_cycle(1);
    mem_rsp_valid = 0;
    #3; chk("after_pop_outst", rd_outst, DEPTH - 1); finish_cycle(1);
    mem_rsp_valid = 1;
    #3;
    chk("pushpop_ready", req_ready, 2'b01);
    chk("pushpop_rspv", rsp_valid, 2'b01);
    chk("pushpop_before", rd_outst, DEPTH - 1);
    finish_cycle(1);
    req_valid = 2'b00; mem_rsp_valid = 0;
    #3; chk("pushpop_after", rd_outst, DEPTH - 1); finish_cycle(1);
    mem_rsp_valid = 1; guard = 0;
    while (m_q.size() > 0 && guard < 20) begin
      #3; finish_cycle(1); guard++;
    end
    mem_rsp_valid = 0;
    #3; chk("drain_outst", rd_outst, 0); finish_cycle(1);

    // Randomized traffic checked against the reference model every cycle.
    p_v = 0; p_rd = 0; p_a[0] = 0; p_a[1] = 0; last_ready = 0; cal_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (p_v[k] && last_ready[k]) p_v[k] = 0;
        if (!p_v[k] && $urandom_range(0, 2) == 0) begin
          p_v[k]  = 1;
          p_rd[k] = 1'($urandom_range(0, 1));
          p_a[k]  = $urandom;
        end
      end
      req_valid = p_v; req_rd = p_rd; req_addr = {p_a[1], p_a[0]};
      mem_rdy = ($urandom_range(0, 9) < 7);
      mem_rsp_valid = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
      if (cal_hold > 0) cal_hold--;
      else if ($urandom_range(0, 299) == 0) cal_hold = $urandom_range(1, 4);
      calib   = (cal_hold == 0);
      reset_i = ($urandom_range(0, 499) == 0);
      #3;
      finish_cycle(1);
      last_ready = e_ready;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
